// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared types and encodings for the cursor sequencer
package cursor_pkg;

  typedef enum logic [1:0] {IDLE, STEP, GAP, SHOT} state_t;
  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;

  localparam logic ADD_INC = 1'b0;
  localparam logic ADD_DEC = 1'b1;

  function automatic logic dir_is_row(dir_t d);
    return (d == UP) || (d == DOWN);
  endfunction

  function automatic logic dir_is_dec(dir_t d);
    return (d == UP) || (d == LEFT);
  endfunction

endpackage

// File: rtl/cursor_ctrl_btn_repeat.sv
// rtl/cursor_ctrl_btn_repeat.sv - direction press detection, capture and auto-repeat timer
module btn_repeat
  import cursor_pkg::*;
#(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic move_req,
  output dir_t move_dir,
  output logic move_rpt
);

  localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  logic [3:0]    lvl;
  logic [3:0]    lvl_q;
  logic [3:0]    press;
  dir_t          press_dir;
  dir_t          cap_dir;
  logic [TW-1:0] timer;
  logic          held;
  logic          rpt;

  assign lvl   = {btn_right, btn_left, btn_down, btn_up};
  assign press = lvl & ~lvl_q;

  always_comb begin
    press_dir = NONE;
    if (press[0])      press_dir = UP;
    else if (press[1]) press_dir = DOWN;
    else if (press[2]) press_dir = LEFT;
    else if (press[3]) press_dir = RIGHT;
  end

  always_comb begin
    held = 1'b0;
    case (cap_dir)
      UP:      held = btn_up;
      DOWN:    held = btn_down;
      LEFT:    held = btn_left;
      RIGHT:   held = btn_right;
      default: held = 1'b0;
    endcase
  end

  // A fresh press always wins over a repeat of the old capture in the same cycle.
  assign rpt      = held && (timer == '0) && (press_dir == NONE);
  assign move_req = (press_dir != NONE) || rpt;
  assign move_dir = (press_dir != NONE) ? press_dir : cap_dir;
  assign move_rpt = rpt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q   <= '0;
      cap_dir <= NONE;
      timer   <= '0;
    end else begin
      lvl_q <= lvl;
      if (press_dir != NONE) begin
        cap_dir <= press_dir;
        timer   <= TW'(REPEAT_DLY - 1);
      end else if (!held) begin
        cap_dir <= NONE;
        timer   <= '0;
      end else if (timer == '0) begin
        timer <= TW'(REPEAT_PER - 1);
      end else begin
        timer <= timer - T_ONE;
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - cursor step/shot sequencer driving the row and column one-hot counters
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int COUNT_WIRES = 2,
  parameter int ROW_INIT    = 0,
  parameter int COL_INIT    = 0,
  parameter int REPEAT_DLY  = 25_000_000,
  parameter int REPEAT_PER  = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_fire,
  input  logic                   shot_ack,
  output logic                   row_en,
  output logic                   col_en,
  output logic                   add_n,
  output logic                   step,
  output logic                   shot_valid,
  output logic [COUNT_WIRES-1:0] shot_row,
  output logic [COUNT_WIRES-1:0] shot_col,
  output logic [COUNT_WIRES-1:0] cur_row,
  output logic [COUNT_WIRES-1:0] cur_col,
  output logic                   busy
);

  localparam logic [COUNT_WIRES-1:0] POS_MAX = '1;
  localparam logic [COUNT_WIRES-1:0] POS_ONE = COUNT_WIRES'(1);

  state_t state, state_d;
  dir_t   dir_q, dir_d;
  dir_t   rpt_dir, rpt_dir_d;
  dir_t   move_dir;
  logic   rpt_pend, rpt_pend_d;
  logic   fire_pend, fire_pend_d;
  logic   fire_q, fire_press;
  logic   move_req, move_rpt;

  btn_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_btn_repeat (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .move_req (move_req),
    .move_dir (move_dir),
    .move_rpt (move_rpt)
  );

  assign fire_press = btn_fire && !fire_q;

  // A step is refused when it would wrap the one-hot counter.
  function automatic logic legal(dir_t d, logic [COUNT_WIRES-1:0] r, logic [COUNT_WIRES-1:0] c);
    case (d)
      UP:      return r != '0;
      DOWN:    return r != POS_MAX;
      LEFT:    return c != '0;
      RIGHT:   return c != POS_MAX;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state;
    dir_d       = dir_q;
    fire_pend_d = fire_pend;
    rpt_pend_d  = rpt_pend;
    rpt_dir_d   = rpt_dir;
    if (move_rpt) begin
      rpt_pend_d = 1'b1;
      rpt_dir_d  = move_dir;
    end
    case (state)
      IDLE: begin
        if (fire_pend || fire_press) begin
          state_d     = SHOT;
          fire_pend_d = 1'b0;
        end else begin
          rpt_pend_d = 1'b0;
          if (move_req && legal(move_dir, cur_row, cur_col)) begin
            state_d = STEP;
            dir_d   = move_dir;
          end else if (rpt_pend && legal(rpt_dir, cur_row, cur_col)) begin
            state_d = STEP;
            dir_d   = rpt_dir;
          end
        end
      end
      STEP:    state_d = GAP;
      GAP:     state_d = IDLE;
      SHOT:    if (shot_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state != IDLE && fire_press) fire_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir_q      <= NONE;
      rpt_dir    <= NONE;
      rpt_pend   <= 1'b0;
      fire_pend  <= 1'b0;
      fire_q     <= 1'b0;
      step       <= 1'b0;
      row_en     <= 1'b0;
      col_en     <= 1'b0;
      add_n      <= ADD_INC;
      shot_valid <= 1'b0;
      busy       <= 1'b0;
      shot_row   <= '0;
      shot_col   <= '0;
      cur_row    <= COUNT_WIRES'(ROW_INIT);
      cur_col    <= COUNT_WIRES'(COL_INIT);
    end else begin
      state      <= state_d;
      dir_q      <= dir_d;
      rpt_dir    <= rpt_dir_d;
      rpt_pend   <= rpt_pend_d;
      fire_pend  <= fire_pend_d;
      fire_q     <= btn_fire;
      step       <= (state_d == STEP);
      row_en     <= (state_d == STEP) && dir_is_row(dir_d);
      col_en     <= (state_d == STEP) && !dir_is_row(dir_d);
      add_n      <= ((state_d == STEP) && dir_is_dec(dir_d)) ? ADD_DEC : ADD_INC;
      shot_valid <= (state_d == SHOT);
      busy       <= (state_d != IDLE);
      if (state == IDLE && state_d == SHOT) begin
        shot_row <= cur_row;
        shot_col <= cur_col;
      end
      // Mirror moves on the same edge that the counters see step.
      if (state == STEP) begin
        case (dir_q)
          UP:      cur_row <= cur_row - POS_ONE;
          DOWN:    cur_row <= cur_row + POS_ONE;
          LEFT:    cur_col <= cur_col - POS_ONE;
          RIGHT:   cur_col <= cur_col + POS_ONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Sequencer for the two one-hot position counters (row and column) that drive the VDC cursor. It turns debounced player buttons into single-cycle step commands with an auto-repeat on hold, and refuses any step that would wrap the counter. It guarantees the counters' fire/step input is never high on two consecutive cycles. Fire requests are issued to the game logic as a valid/ack handshake carrying the current cursor coordinate.

## Interface
Parameters:
- COUNT_WIRES, 2: counter width; grid is 2**COUNT_WIRES per axis.
- ROW_INIT, 0: cursor row after reset; must equal the row counter's load value.
- COL_INIT, 0: cursor column after reset; must equal the column counter's load value.
- REPEAT_DLY, 25_000_000: cycles a direction must be held before the first repeat step.
- REPEAT_PER, 10_000_000: cycles between subsequent repeat steps.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_up / btn_down / btn_left / btn_right  in  1 each  debounced, synchronous levels.
- btn_fire  in  1  debounced, synchronous level.
- shot_ack  in  1  game logic accepts the shot.
- row_en  out  1  to row counter.
- col_en  out  1  to column counter.
- add_n  out  1  0 = increment, 1 = decrement.
- step  out  1  to the counters' fire input.
- shot_valid  out  1  shot request pending.
- shot_row / shot_col  out  COUNT_WIRES each  coordinate of the pending shot.
- cur_row / cur_col  out  COUNT_WIRES each  mirror of the counter values.
- busy  out  1  state is not IDLE.

## Operation
- All outputs are registered. Press = level high now and low on the previous cycle.
- Direction mapping: down = row +1, up = row −1, right = col +1, left = col −1. The add_n output follows the same sign convention.
- Fixed priority for simultaneous requests: fire > up > down > left > right.
- Auto-repeat:
  - A direction press captures that direction and loads the repeat timer with REPEAT_DLY.
  - While the captured button stays high, timer expiry generates a repeat request and reloads the timer with REPEAT_PER.
  - Releasing the captured button clears the capture. A press of another direction replaces the capture.
- Boundary rule: a request to decrement from 0, or to increment from 2**COUNT_WIRES−1, is dropped. No step is issued and the cursor is unchanged.
- FSM states:
  - IDLE:
    - If fire_pend or a fire press is present, go to SHOT.
    - Otherwise, if a legal move request is present, go to STEP.
  - STEP:
    - step = 1 together with exactly one of row_en/col_en, plus add_n.
    - cur_row or cur_col updates at the end of this cycle, on the same edge as the counter.
    - Go to GAP.
  - GAP: all command outputs are 0. Go to IDLE.
  - SHOT:
    - On entry, shot_row/shot_col latch cur_row/cur_col.
    - shot_valid stays high until the cycle shot_ack = 1, then go to IDLE with shot_valid = 0.
- A fire press outside IDLE sets fire_pend, which is serviced on the next IDLE cycle. A second press while fire_pend is already set is dropped.
- Direction presses outside IDLE are dropped. A repeat request is not dropped: it stays pending until IDLE.
- shot_ack outside SHOT is ignored.

## Timing
- Reset state:
  - FSM is IDLE.
  - step, row_en, col_en, add_n, shot_valid and busy are 0.
  - cur_row = ROW_INIT and cur_col = COL_INIT; shot_row/shot_col are 0.
  - fire_pend and the repeat capture are cleared.
- Latency, button to command: a press seen at edge N gives step = 1 during cycle N+1, then GAP at N+2. IDLE is reached at N+3.
- step is high for exactly one cycle and is always followed by at least one low cycle. The minimum step period is 3 cycles.
- Fire latency: a press at edge N gives shot_valid = 1 from cycle N+1. If shot_ack is high in cycle M, shot_valid = 0 from cycle M+1.
- Reset asserted mid-STEP or mid-SHOT: outputs clear immediately (asynchronous); any pending request is lost.

## Structure
- Package cursor_pkg holds:
  - the state enum (IDLE, STEP, GAP, SHOT);
  - the direction enum (NONE, UP, DOWN, LEFT, RIGHT);
  - the add_n encoding constants (ADD_INC = 0, ADD_DEC = 1).
- One sub-module, btn_repeat, contains the press detection, direction capture and repeat timer. It outputs a single-cycle move request and its direction.
- The top-level holds the FSM, the boundary check, fire_pend, the cursor mirrors and the shot latch.

## Test plan
- Single move: reset with ROW_INIT = 1; pulse btn_down for 1 cycle → exactly one cycle with step = 1, row_en = 1, add_n = 0; then cur_row = 2 and the counter output is 0100.
- Boundary: cursor at col 3; press btn_right, then hold it past REPEAT_DLY → no step ever asserted; cur_col stays 3.
- Auto-repeat: set REPEAT_DLY = 8 and REPEAT_PER = 4; hold btn_up from row 3 → steps at press+1, then at +8 and +12; stops at row 0 with no further steps.
- Simultaneous events: btn_fire and btn_left press in the same cycle → SHOT entered first; hold shot_ack low for 5 cycles and check shot_valid stays high with the coordinate stable; after ack, the left press is dropped (no step).
- Fire during a step: press btn_fire in the STEP cycle → fire_pend is set; shot_valid rises after GAP and IDLE, and carries the post-step coordinate.
- Reset mid-SHOT: assert rst while shot_valid = 1 → shot_valid and busy fall immediately; cursor returns to (ROW_INIT, COL_INIT).
